// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes rx, finds the start bit, samples mid-bit
// and presents the byte with parity, framing and overrun flags.
module uart_rx_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic        rx_s, rx_prev, fall, expire;
  logic [3:0]  cfg_baud;
  logic        cfg_eight, cfg_par, cfg_odd;
  logic [3:0]  bit_cnt, frame_len, n_cur;
  logic [18:0] samp_cnt, k_live, k_cur;
  logic [9:0]  shreg, aligned;
  logic [7:0]  data_new;
  logic        par_bit;

  function automatic logic [18:0] bit_time(input logic [3:0] code);
    case (code)
      4'd0:    bit_time = 19'd333333;
      4'd1:    bit_time = 19'd83333;
      4'd2:    bit_time = 19'd41667;
      4'd3:    bit_time = 19'd20833;
      4'd4:    bit_time = 19'd10417;
      4'd5:    bit_time = 19'd5208;
      4'd6:    bit_time = 19'd2604;
      4'd7:    bit_time = 19'd1736;
      4'd9:    bit_time = 19'd434;
      4'd10:   bit_time = 19'd217;
      4'd11:   bit_time = 19'd109;
      default: bit_time = 19'd868;
    endcase
  endfunction

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '1;
    else       sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  assign rx_s      = sync[SYNC_STAGES-1];
  assign fall      = rx_prev & ~rx_s;
  // Expiring at 1 rather than 0 makes a reload of k span exactly k clocks.
  assign expire    = (samp_cnt <= 19'd1);
  assign frame_len = 4'd9 + {3'b000, eight} + {3'b000, parity_en};
  assign n_cur     = 4'd9 + {3'b000, cfg_eight} + {3'b000, cfg_par};
  assign k_live    = bit_time(baud);
  assign k_cur     = bit_time(cfg_baud);
  assign aligned   = shreg >> (4'd11 - n_cur);
  assign data_new  = cfg_eight ? aligned[7:0] : {1'b0, aligned[6:0]};
  assign par_bit   = cfg_eight ? aligned[8] : aligned[7];
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (expire) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (expire && bit_cnt == 4'd1) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rx_prev    <= 1'b1;
      cfg_baud   <= 4'd0;
      cfg_eight  <= 1'b0;
      cfg_par    <= 1'b0;
      cfg_odd    <= 1'b0;
      bit_cnt    <= 4'd0;
      samp_cnt   <= 19'd0;
      shreg      <= 10'd0;
      rx_data    <= 8'h00;
      rxrdy      <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_prev <= rx_s;
      case (state)
        IDLE: if (fall) begin
          cfg_baud  <= baud;
          cfg_eight <= eight;
          cfg_par   <= parity_en;
          cfg_odd   <= odd_n_even;
          bit_cnt   <= frame_len;
          samp_cnt  <= k_live >> 1;
          shreg     <= 10'd0;
        end
        START, DATA: begin
          if (expire) begin
            samp_cnt <= k_cur;
            bit_cnt  <= bit_cnt - 4'd1;
            if (state == DATA) shreg <= {rx_s, shreg[9:1]};
          end else begin
            samp_cnt <= samp_cnt - 19'd1;
          end
        end
        default: ;
      endcase
      // A read landing on DONE loses to the new frame.
      if (state == DONE) begin
        rx_data <= data_new;
        rxrdy   <= 1'b1;
        ferr    <= ~shreg[9];
        perr    <= cfg_par & ((^data_new ^ par_bit) != cfg_odd);
        ovf     <= rxrdy & ~read;
      end else if (read) begin
        rxrdy <= 1'b0;
        perr  <= 1'b0;
        ferr  <= 1'b0;
        ovf   <= 1'b0;
      end
    end
  end

endmodule
